// File: rtl/clcd_responder_if.sv
// 8-bit HD44780-style character-LCD bus: the driver is the master, the display-side responder the slave.
interface clcd_responder_if;
   logic       lcd_e;
   logic       lcd_rs;
   logic       lcd_rw;
   logic [7:0] lcd_data_in;
   logic [7:0] lcd_data_out;
   logic       lcd_data_oe;

   modport master (output lcd_e, lcd_rs, lcd_rw, lcd_data_in, input lcd_data_out, lcd_data_oe);
   modport slave  (input lcd_e, lcd_rs, lcd_rw, lcd_data_in, output lcd_data_out, lcd_data_oe);
endinterface

// File: rtl/clcd_responder.sv
// Display-side responder for the character-LCD bus: decodes instructions, holds the 2x16 DDRAM image.
// Define CLCD_BUSY_MODEL_EN to add controller execution time (HOLD state) to the busy flag.
module clcd_responder
`ifdef CLCD_BUSY_MODEL_EN
#(
   parameter int CLR_CYCLES  = 64,
   parameter int EXEC_CYCLES = 8
)
`endif
(
   input  logic                   clk,
   input  logic                   rst,
   clcd_responder_if.slave        bus,
   input  logic [4:0]             rd_addr,
   output logic [7:0]             rd_data,
   output logic                   disp_on,
   output logic                   cursor_on,
   output logic                   blink_on,
   output logic                   entry_inc,
   output logic                   func_8bit,
   output logic                   func_2line,
   output logic [6:0]             ac,
   output logic                   busy,
   output logic                   overrun
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL
`ifdef CLCD_BUSY_MODEL_EN
      , S_HOLD
`endif
   } state_t;

   state_t      r_state;
   logic        r_e1, r_e2, r_e3, r_rs1, r_rs2, r_rw1, r_rw2;
   logic [7:0]  r_d1, r_d2;
   logic [4:0]  r_fillIdx;
   logic [7:0]  r_image [32];
   logic [6:0]  r_ac;
   logic        r_dispOn, r_cursorOn, r_blinkOn, r_entryInc, r_func8bit, r_func2line;
   logic        r_cgMode, r_busy, r_overrun, r_dataOe;
   logic [7:0]  r_dataOut, r_rdData;
`ifdef CLCD_BUSY_MODEL_EN
   logic [15:0] r_holdCnt;
   logic        r_fillHold;
   logic        w_isHome, w_isExec;
`endif
   logic        w_rise, w_fall, w_inWin, w_write, w_isClr;
   logic [4:0]  w_idx;
   logic [7:0]  w_readByte;

   // DDRAM address step with the two-line wrap points; out-of-range values step as plain 7-bit +/-1.
   function automatic logic [6:0] acStep(input logic [6:0] a, input logic inc);
      if (inc) begin
         case (a)
            7'h27:   return 7'h40;
            7'h67:   return 7'h00;
            default: return a + 7'd1;
         endcase
      end else begin
         case (a)
            7'h40:   return 7'h27;
            7'h00:   return 7'h67;
            default: return a - 7'd1;
         endcase
      end
   endfunction

   always_comb begin
      w_rise     = r_e2 & ~r_e3;
      w_fall     = ~r_e2 & r_e3;
      w_inWin    = (r_ac[5:4] == 2'b00);
      w_idx      = {r_ac[6], r_ac[3:0]};
      w_readByte = w_inWin ? r_image[w_idx] : 8'h20;
      w_write    = w_fall & ~r_rw2 & (r_state == S_IDLE);
      w_isClr    = w_write & ~r_rs2 & (r_d2 == 8'h01);
`ifdef CLCD_BUSY_MODEL_EN
      w_isHome   = w_write & ~r_rs2 & (r_d2[7:1] == 7'h01);
      w_isExec   = w_write & (r_rs2 | (r_d2[7:2] != 6'h00));
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         {r_e1, r_e2, r_e3, r_rs1, r_rs2, r_rw1, r_rw2} <= '0;
         r_d1        <= 8'h00;
         r_d2        <= 8'h00;
         r_state     <= S_FILL;
         r_fillIdx   <= 5'd0;
         r_ac        <= 7'h00;
         r_dispOn    <= 1'b0;
         r_cursorOn  <= 1'b0;
         r_blinkOn   <= 1'b0;
         r_entryInc  <= 1'b1;
         r_func8bit  <= 1'b1;
         r_func2line <= 1'b0;
         r_cgMode    <= 1'b0;
         r_busy      <= 1'b0;
         r_overrun   <= 1'b0;
         r_dataOe    <= 1'b0;
         r_dataOut   <= 8'h00;
         r_rdData    <= 8'h20;
`ifdef CLCD_BUSY_MODEL_EN
         r_holdCnt   <= 16'd0;
         r_fillHold  <= 1'b0;
`endif
      end else begin
         r_e1  <= bus.lcd_e;        r_e2  <= r_e1;  r_e3 <= r_e2;
         r_rs1 <= bus.lcd_rs;       r_rs2 <= r_rs1;
         r_rw1 <= bus.lcd_rw;       r_rw2 <= r_rw1;
         r_d1  <= bus.lcd_data_in;  r_d2  <= r_d1;
         r_rdData <= r_image[rd_addr];

         case (r_state)
            S_FILL: begin
               r_image[r_fillIdx] <= 8'h20;
               r_fillIdx          <= r_fillIdx + 5'd1;
               if (r_fillIdx == 5'd31) begin
`ifdef CLCD_BUSY_MODEL_EN
                  if (r_fillHold && (CLR_CYCLES > 32)) begin
                     r_state   <= S_HOLD;
                     r_holdCnt <= 16'(CLR_CYCLES - 33);
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
`else
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
`endif
               end else begin
                  r_busy <= 1'b1;
               end
            end
`ifdef CLCD_BUSY_MODEL_EN
            S_HOLD: begin
               if (r_holdCnt == 16'd0) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_holdCnt <= r_holdCnt - 16'd1;
               end
            end
`endif
            default: ;
         endcase

         // Reads latch their answer on E rising and release the bus on E falling.
         if (w_rise && r_rw2) begin
            r_dataOe  <= 1'b1;
            r_dataOut <= r_rs2 ? w_readByte : {r_busy, r_ac};
         end

         if (w_fall) begin
            if (r_rw2) begin
               r_dataOe <= 1'b0;
               if (r_rs2) r_ac <= acStep(r_ac, r_entryInc);
            end else if (r_state != S_IDLE) begin
               r_overrun <= 1'b1;
            end else if (r_rs2) begin
               if (!r_cgMode) begin
                  if (w_inWin) r_image[w_idx] <= r_d2;
                  r_ac <= acStep(r_ac, r_entryInc);
               end
            end else begin
               casez (r_d2)
                  8'b1???????: begin r_ac <= r_d2[6:0]; r_cgMode <= 1'b0; end
                  8'b01??????: r_cgMode <= 1'b1;
                  8'b001?????: begin r_func8bit <= r_d2[4]; r_func2line <= r_d2[3]; end
                  8'b0001????: if (!r_d2[3]) r_ac <= acStep(r_ac, r_d2[2]);
                  8'b00001???: begin
                     r_dispOn   <= r_d2[2];
                     r_cursorOn <= r_d2[1];
                     r_blinkOn  <= r_d2[0];
                  end
                  8'b000001??: r_entryInc <= r_d2[1];
                  8'b0000001?: begin r_ac <= 7'h00; r_cgMode <= 1'b0; end
                  8'b00000001: begin r_ac <= 7'h00; r_entryInc <= 1'b1; r_cgMode <= 1'b0; end
                  default: ;
               endcase
            end
         end

         if (w_isClr) begin
            r_state   <= S_FILL;
            r_fillIdx <= 5'd0;
            r_busy    <= 1'b1;
`ifdef CLCD_BUSY_MODEL_EN
            r_fillHold <= 1'b1;
         end else if (w_isHome) begin
            r_state   <= S_HOLD;
            r_holdCnt <= 16'(CLR_CYCLES - 1);
            r_busy    <= 1'b1;
         end else if (w_isExec && (EXEC_CYCLES > 0)) begin
            r_state   <= S_HOLD;
            r_holdCnt <= 16'(EXEC_CYCLES - 1);
            r_busy    <= 1'b1;
`endif
         end
      end
   end

   assign bus.lcd_data_out = r_dataOut;
   assign bus.lcd_data_oe  = r_dataOe;
   assign rd_data          = r_rdData;
   assign disp_on          = r_dispOn;
   assign cursor_on        = r_cursorOn;
   assign blink_on         = r_blinkOn;
   assign entry_inc        = r_entryInc;
   assign func_8bit        = r_func8bit;
   assign func_2line       = r_func2line;
   assign ac               = r_ac;
   assign busy             = r_busy;
   assign overrun          = r_overrun;

endmodule

// File: tb/tb_clcd_responder.sv
// Directed bench for clcd_responder: drives bus transactions and compares against hand-computed values.
module tb_clcd_responder;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rdAddr;
   logic [7:0] rdData;
   logic       dispOn, cursorOn, blinkOn, entryInc, func8bit, func2line, busy, overrun;
   logic [6:0] ac;
   int         checkCount = 0;
   int         errorCount = 0;
   logic [7:0] value;
   logic       oeHigh, oeAfter;
   int         busyCount;

   clcd_responder_if bus();

   clcd_responder dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .rd_addr    (rdAddr),
      .rd_data    (rdData),
      .disp_on    (dispOn),
      .cursor_on  (cursorOn),
      .blink_on   (blinkOn),
      .entry_inc  (entryInc),
      .func_8bit  (func8bit),
      .func_2line (func2line),
      .ac         (ac),
      .busy       (busy),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // One write strobe; returns on the cycle E drops so callers can time the commit.
   task automatic lcdPulse(input logic rs, input logic [7:0] d);
      @(negedge clk);
      bus.lcd_rs = rs; bus.lcd_rw = 1'b0; bus.lcd_data_in = d;
      repeat (2) @(negedge clk);
      bus.lcd_e = 1'b1;
      repeat (4) @(negedge clk);
      bus.lcd_e = 1'b0;
   endtask

   task automatic applyStimulus(input logic rs, input logic [7:0] d);
      lcdPulse(rs, d);
      repeat (6) @(negedge clk);
   endtask

   task automatic waitIdle();
      int n = 0;
      while (busy && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (busy) checkOutput("idleTimeout", busy, 0);
   endtask

   task automatic sendIdle(input logic rs, input logic [7:0] d);
      applyStimulus(rs, d);
      waitIdle();
   endtask

   task automatic applyRead(input logic rs, output logic [7:0] data, output logic oeH, output logic oeA);
      @(negedge clk);
      bus.lcd_rs = rs; bus.lcd_rw = 1'b1;
      repeat (2) @(negedge clk);
      bus.lcd_e = 1'b1;
      repeat (5) @(negedge clk);
      data = bus.lcd_data_out;
      oeH  = bus.lcd_data_oe;
      bus.lcd_e = 1'b0;
      repeat (5) @(negedge clk);
      oeA = bus.lcd_data_oe;
      bus.lcd_rw = 1'b0;
   endtask

   task automatic readImage(input logic [4:0] idx, output logic [7:0] data);
      @(negedge clk);
      rdAddr = idx;
      @(negedge clk);
      data = rdData;
   endtask

   task automatic checkBlank(input string tag);
      logic [7:0] v;
      for (int i = 0; i < 32; i++) begin
         readImage(5'(i), v);
         checkOutput(tag, v, 8'h20);
      end
   endtask

   initial begin
      #2ms;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.lcd_e = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_data_in = 8'h00;
      rdAddr = 5'd0;
      repeat (3) @(negedge clk);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstAc", ac, 7'h00);
      checkOutput("rstEntryInc", entryInc, 1);
      checkOutput("rstFunc8", func8bit, 1);
      checkOutput("rstFunc2", func2line, 0);
      checkOutput("rstDisp", {dispOn, cursorOn, blinkOn}, 3'b000);
      checkOutput("rstRdData", rdData, 8'h20);
      checkOutput("rstOe", bus.lcd_data_oe, 0);
      checkOutput("rstDataOut", bus.lcd_data_out, 8'h00);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rstFillBusy", busy, 1);
      waitIdle();
      checkBlank("rstBlank");

      sendIdle(0, 8'h38);
      sendIdle(0, 8'h0C);
      sendIdle(0, 8'h06);
      checkOutput("initFunc8", func8bit, 1);
      checkOutput("initFunc2", func2line, 1);
      checkOutput("initDisp", {dispOn, cursorOn, blinkOn}, 3'b100);
      checkOutput("initEntry", entryInc, 1);
      checkOutput("initOverrun", overrun, 0);

      sendIdle(0, 8'h80);
      sendIdle(1, 8'h59); sendIdle(1, 8'h4F); sendIdle(1, 8'h55);
      readImage(5'd0, value); checkOutput("youIdx0", value, 8'h59);
      readImage(5'd1, value); checkOutput("youIdx1", value, 8'h4F);
      readImage(5'd2, value); checkOutput("youIdx2", value, 8'h55);
      checkOutput("youAc", ac, 7'h03);

      sendIdle(0, 8'hC0);
      sendIdle(1, 8'h47); sendIdle(1, 8'h41); sendIdle(1, 8'h4D); sendIdle(1, 8'h45);
      readImage(5'd16, value); checkOutput("gameIdx16", value, 8'h47);
      readImage(5'd17, value); checkOutput("gameIdx17", value, 8'h41);
      readImage(5'd18, value); checkOutput("gameIdx18", value, 8'h4D);
      readImage(5'd19, value); checkOutput("gameIdx19", value, 8'h45);
      checkOutput("gameAc", ac, 7'h44);

      lcdPulse(0, 8'h01);
      busyCount = 0;
      repeat (100) begin
         @(negedge clk);
         if (busy) busyCount++;
      end
`ifdef CLCD_BUSY_MODEL_EN
      checkOutput("clrBusyLen", busyCount, 64);
`else
      checkOutput("clrBusyLen", busyCount, 32);
`endif
      checkOutput("clrAc", ac, 7'h00);
      checkBlank("clrBlank");

      sendIdle(0, 8'hA7);
      sendIdle(1, 8'h41);
      checkOutput("wrapUpAc", ac, 7'h40);
      readImage(5'd7, value); checkOutput("dropIdx7", value, 8'h20);
      sendIdle(0, 8'h04);
      checkOutput("entryDec", entryInc, 0);
      sendIdle(1, 8'h42);
      readImage(5'd16, value); checkOutput("decIdx16", value, 8'h42);
      checkOutput("wrapDnAc", ac, 7'h27);

      applyRead(0, value, oeHigh, oeAfter);
      checkOutput("rdStatus", value, 8'h27);
      checkOutput("rdStatusOe", oeHigh, 1);
      checkOutput("rdStatusOeOff", oeAfter, 0);

      sendIdle(0, 8'h06);
      sendIdle(0, 8'h80);
      sendIdle(1, 8'h59);
      sendIdle(0, 8'h80);
      applyRead(1, value, oeHigh, oeAfter);
      checkOutput("rdData", value, 8'h59);
      checkOutput("rdDataOe", oeHigh, 1);
      checkOutput("rdDataOeOff", oeAfter, 0);
      checkOutput("rdDataAc", ac, 7'h01);

      sendIdle(0, 8'hE7);
      sendIdle(1, 8'h11);
      checkOutput("wrap67Ac", ac, 7'h00);
      sendIdle(0, 8'h14);
      checkOutput("shiftRight", ac, 7'h01);
      sendIdle(0, 8'h10);
      sendIdle(0, 8'h10);
      checkOutput("shiftLeftWrap", ac, 7'h67);
      sendIdle(0, 8'h18);
      checkOutput("dispShiftNoAc", ac, 7'h67);

      sendIdle(0, 8'h80);
      sendIdle(0, 8'h40);
      sendIdle(1, 8'h55);
      checkOutput("cgAc", ac, 7'h00);
      readImage(5'd0, value); checkOutput("cgIdx0", value, 8'h59);
      sendIdle(0, 8'h80);
      sendIdle(1, 8'h51);
      readImage(5'd0, value); checkOutput("ddIdx0", value, 8'h51);
      checkOutput("ddAc", ac, 7'h01);

      applyStimulus(0, 8'h02);
`ifdef CLCD_BUSY_MODEL_EN
      checkOutput("homeBusy", busy, 1);
`else
      checkOutput("homeBusy", busy, 0);
`endif
      waitIdle();
      checkOutput("homeAc", ac, 7'h00);

`ifdef CLCD_BUSY_MODEL_EN
      lcdPulse(0, 8'h01);
      repeat (3) @(negedge clk);
      applyRead(0, value, oeHigh, oeAfter);
      checkOutput("rdBusyStatus", value, 8'h80);
      waitIdle();
`endif

      sendIdle(0, 8'h80);
      sendIdle(1, 8'h5A);
      applyStimulus(0, 8'h01);
      applyStimulus(1, 8'h33);
      waitIdle();
      checkOutput("overrunSet", overrun, 1);
      readImage(5'd0, value); checkOutput("overrunIdx0", value, 8'h20);
      checkOutput("overrunAc", ac, 7'h00);

      sendIdle(0, 8'h04);
      sendIdle(1, 8'h5A);
      lcdPulse(0, 8'h01);
      repeat (12) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      waitIdle();
      checkOutput("midRstOverrun", overrun, 0);
      checkOutput("midRstFunc2", func2line, 0);
      checkOutput("midRstEntry", entryInc, 1);
      checkOutput("midRstAc", ac, 7'h00);
      checkBlank("midRstBlank");

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
